spi_slave_rx: RTL and testbench

Serial endpoint consuming the `cs`/`sclk`/`mosi` lines driven by the SPI master and producing `miso` back to it. All pin inputs are oversampled in the system clock domain. Received words are delivered as a parallel word with a one-cycle valid strobe, and a response word is accepted through a load handshake. It serves both as the loopback peer in master regression benches and as the device-side interface in register-bridge designs.

---
 rtl/spi_slave_rx_pkg.sv | 26 ++
 rtl/spi_slave_rx_if.sv | 45 ++++
 rtl/spi_slave_rx_sync2.sv | 32 +++
 rtl/spi_slave_rx.sv | 219 +++++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_rx_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI slave receiver slice.
//   spi_state_t : receiver FSM states (IDLE, LOAD, SHIFT)
//   SPI_MODEn   : {CPOL, CPHA} encodings of the four SPI modes
//   spi_cnt_w() : bit-counter width for a given word width, $clog2(DATA_WIDTH)
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Counter must hold 0 .. DATA_WIDTH-1.
  function automatic int spi_cnt_w(input int data_width);
    return (data_width < 2) ? 1 : $clog2(data_width);
  endfunction

endpackage

// File: rtl/spi_slave_rx_if.sv
// -----------------------------------------------------------------------------
// spi_slave_rx_if
// Bundles the SPI pins and the parallel receive/transmit handshake of
// spi_slave_rx.
//   cs, sclk, mosi : pins driven by the SPI master
//   miso           : pin driven back by the slave
//   rx_data/rx_valid : received word and its one-cycle strobe
//   tx_data/tx_load/tx_ready : response word load handshake
//   rx_overrun     : sticky overrun flag (only with SPI_SLAVE_OVERRUN_EN)
// Modports: slave (the receiver), master (pin driver / host side).
// -----------------------------------------------------------------------------
interface spi_slave_rx_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  cs;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_ready;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic                  rx_overrun;
`endif

  modport slave (
    input  cs, sclk, mosi, tx_data, tx_load,
`ifdef SPI_SLAVE_OVERRUN_EN
    output rx_overrun,
`endif
    output miso, rx_data, rx_valid, tx_ready
  );

  modport master (
    output cs, sclk, mosi, tx_data, tx_load,
`ifdef SPI_SLAVE_OVERRUN_EN
    input  rx_overrun,
`endif
    input  miso, rx_data, rx_valid, tx_ready
  );

endinterface

// File: rtl/spi_slave_rx_sync2.sv
// -----------------------------------------------------------------------------
// spi_sync2
// Parameterised-width two-flop synchronizer with asynchronous active-high
// reset. Each bit resets to the matching bit of RST_VAL so that an idle bus
// does not look like an edge when reset is released.
//   clk, rst : system clock / async reset
//   d        : asynchronous inputs
//   q        : inputs resynchronised to clk
// -----------------------------------------------------------------------------
module spi_sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= RST_VAL;
      q       <= RST_VAL;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
// SPI slave endpoint. Pins are oversampled in the clk domain: two-flop
// synchronizer, one more register for edge detection, then an FSM that
// shifts mosi into a receive register and drives miso from a transmit shift
// register loaded from a one-word holding register.
//
// Parameters : CPOL (sclk idle level), CPHA (0 = sample on leading edge),
//              DATA_WIDTH (bits per word, MSB first, >= 2)
// Ports      : clk, rst (async, active high), bus (spi_slave_rx_if.slave):
//              cs/sclk/mosi in, miso out, rx_data/rx_valid out,
//              tx_data/tx_load in, tx_ready out, rx_overrun out (optional)
// Build macro: SPI_SLAVE_OVERRUN_EN adds the sticky rx_overrun flag.
// -----------------------------------------------------------------------------
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  spi_slave_rx_if.slave bus
);

  localparam int               CNT_W    = spi_cnt_w(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic             IDLE_LVL = (CPOL != 0);
  localparam logic [1:0]       MODE     = {IDLE_LVL, logic'(CPHA != 0)};
  // Modes 0/1 idle low, so their leading edge is the rising one.
  localparam logic LEAD_IS_RISE   = (MODE == SPI_MODE0) || (MODE == SPI_MODE1);
  localparam logic SAMPLE_ON_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);

  // ---- stage p1: pin synchronisation --------------------------------------
  logic [2:0] pins_p1;
  logic       cs_p1;
  logic       sclk_p1;
  logic       mosi_p1;

  spi_sync2 #(
    .WIDTH   (3),
    .RST_VAL ({1'b1, IDLE_LVL, 1'b0})
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({bus.cs, bus.sclk, bus.mosi}),
    .q   (pins_p1)
  );

  assign cs_p1   = pins_p1[2];
  assign sclk_p1 = pins_p1[1];
  assign mosi_p1 = pins_p1[0];

  // ---- stage p2: edge detection --------------------------------------------
  logic cs_p2;
  logic sclk_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_p2   <= 1'b1;
      sclk_p2 <= IDLE_LVL;
    end else begin
      cs_p2   <= cs_p1;
      sclk_p2 <= sclk_p1;
    end
  end

  logic sclk_rise;
  logic sclk_fall;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;
  logic cs_fall;
  logic cs_rise;

  assign sclk_rise   = sclk_p1 & ~sclk_p2;
  assign sclk_fall   = ~sclk_p1 & sclk_p2;
  assign lead_edge   = LEAD_IS_RISE ? sclk_rise : sclk_fall;
  assign trail_edge  = LEAD_IS_RISE ? sclk_fall : sclk_rise;
  assign sample_edge = SAMPLE_ON_LEAD ? lead_edge : trail_edge;
  assign shift_edge  = SAMPLE_ON_LEAD ? trail_edge : lead_edge;
  assign cs_fall     = cs_p2 & ~cs_p1;
  assign cs_rise     = ~cs_p2 & cs_p1;

  // ---- stage p3: FSM and shift registers -----------------------------------
  spi_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  miso_r;
  logic                  rx_done;

  logic [DATA_WIDTH-1:0] hold_data;
  logic                  tx_ready_r;
  logic [DATA_WIDTH-1:0] load_word;
  logic                  tx_accept;

  // An empty holding register sends zeros.
  assign load_word = tx_ready_r ? '0 : hold_data;
  assign tx_accept = bus.tx_load & tx_ready_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      miso_r   <= 1'b0;
      rx_done  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (cs_rise) begin
        // Abort: drop any partial word, holding register untouched.
        state  <= IDLE;
        cnt    <= '0;
        miso_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            miso_r <= 1'b0;
            cnt    <= '0;
            if (cs_fall) state <= LOAD;
          end
          LOAD: begin
            cnt <= '0;
            if (SAMPLE_ON_LEAD) begin
              // MSB must be on the pin before the first (sampling) edge.
              miso_r   <= load_word[DATA_WIDTH-1];
              tx_shift <= {load_word[DATA_WIDTH-2:0], 1'b0};
            end else begin
              tx_shift <= load_word;
            end
            state <= SHIFT;
          end
          SHIFT: begin
            if (sample_edge) begin
              rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_p1};
              if (cnt == LAST_CNT) begin
                cnt     <= '0;
                rx_done <= 1'b1;
                state   <= cs_p1 ? IDLE : LOAD;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            // With sample-on-lead, the trailing edge right after LOAD would
            // otherwise skip over the freshly loaded MSB.
            if (shift_edge && (!SAMPLE_ON_LEAD || (cnt != '0))) begin
              miso_r   <= tx_shift[DATA_WIDTH-1];
              tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // ---- stage p4: output registers and holding register ---------------------
  logic [DATA_WIDTH-1:0] rx_data_r;
  logic                  rx_valid_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      hold_data  <= '0;
      tx_ready_r <= 1'b1;
    end else begin
      rx_valid_r <= rx_done;
      if (rx_done) rx_data_r <= rx_shift;
      // A load accepted in the LOAD cycle lands after the old contents were
      // consumed, so the register stays full.
      if (tx_accept) begin
        hold_data  <= bus.tx_data;
        tx_ready_r <= 1'b0;
      end else if (state == LOAD) begin
        tx_ready_r <= 1'b1;
      end
    end
  end

  assign bus.miso     = miso_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.tx_ready = tx_ready_r;

`ifdef SPI_SLAVE_OVERRUN_EN
  // unacked: the LOAD following a completed word found no response loaded,
  // i.e. the host never reacted to that word.
  logic unacked;
  logic rx_overrun_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unacked      <= 1'b0;
      rx_overrun_r <= 1'b0;
    end else begin
      if (state == LOAD) begin
        unacked <= rx_done & tx_ready_r & ~tx_accept;
      end else if (tx_accept) begin
        unacked <= 1'b0;
      end
      // rx_done is high in the cycle after a completion, before unacked is
      // refreshed for the new word.
      if (rx_done && unacked) begin
        rx_overrun_r <= 1'b1;
      end else if (tx_accept) begin
        rx_overrun_r <= 1'b0;
      end
    end
  end

  assign bus.rx_overrun = rx_overrun_r;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
`timescale 1ns/1ps
module tb_spi_slave_rx;
  import spi_pkg::*;

  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         sel = 0;
  logic       m_cs = 1'b1;
  logic       m_sclk = 1'b0;
  logic       m_mosi = 1'b0;
  logic       m_tx_load = 1'b0;
  logic [7:0] m_tx_data = 8'h00;
  logic [7:0] mi;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spi_slave_rx_if #(.DATA_WIDTH(8)) if0 ();
  spi_slave_rx_if #(.DATA_WIDTH(8)) if3 ();

  assign if0.cs      = (sel == 0) ? m_cs : 1'b1;
  assign if0.sclk    = (sel == 0) ? m_sclk : 1'b0;
  assign if0.mosi    = m_mosi;
  assign if0.tx_data = m_tx_data;
  assign if0.tx_load = (sel == 0) & m_tx_load;
  assign if3.cs      = (sel == 3) ? m_cs : 1'b1;
  assign if3.sclk    = (sel == 3) ? m_sclk : 1'b1;
  assign if3.mosi    = m_mosi;
  assign if3.tx_data = m_tx_data;
  assign if3.tx_load = (sel == 3) & m_tx_load;

  spi_slave_rx #(.CPOL(0), .CPHA(0), .DATA_WIDTH(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  spi_slave_rx #(.CPOL(1), .CPHA(1), .DATA_WIDTH(8)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_rx(input string name, input logic [7:0] d);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: unexpected rx_valid with 0x%0h, expected none", name, d);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(d), 32'(e));
    end
  endtask

  // Scoreboard monitor: pops one expected word per rx_valid strobe.
  always @(negedge clk) begin
    if (if0.rx_valid) mon_rx("rx_data mode0", if0.rx_data);
    if (if3.rx_valid) mon_rx("rx_data mode3", if3.rx_data);
  end

  function automatic logic cur_miso();
    return (sel == 3) ? if3.miso : if0.miso;
  endfunction

  function automatic logic cur_ready();
    return (sel == 3) ? if3.tx_ready : if0.tx_ready;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_tx(input logic [7:0] v);
    m_tx_data = v;
    m_tx_load = 1'b1;
    tick(1);
    m_tx_load = 1'b0;
    tick(1);
  endtask

  task automatic cs_assert();
    m_cs = 1'b0;
    tick(6);
  endtask

  task automatic cs_deassert();
    tick(HALF);
    m_cs = 1'b1;
    tick(8);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (sel == 0) begin
        m_mosi = mo[7-i];
        tick(HALF);
        m_sclk = 1'b1;
        rd[7-i] = cur_miso();
        tick(HALF);
        m_sclk = 1'b0;
      end else begin
        m_sclk = 1'b0;
        m_mosi = mo[7-i];
        tick(HALF);
        m_sclk = 1'b1;
        rd[7-i] = cur_miso();
        tick(HALF);
      end
    end
  endtask

  initial begin
    // Reset values
    tick(3);
    check("reset miso", 32'(if0.miso), 32'h0);
    check("reset rx_data", 32'(if0.rx_data), 32'h0);
    check("reset rx_valid", 32'(if0.rx_valid), 32'h0);
    check("reset tx_ready", 32'(if0.tx_ready), 32'h1);
    check("reset tx_ready mode3", 32'(if3.tx_ready), 32'h1);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("reset rx_overrun", 32'(if0.rx_overrun), 32'h0);
`endif
    rst = 1'b0;
    tick(4);

    // Mode 0: preload 0x3C, receive 0xA5
    sel = 0;
    m_sclk = 1'b0;
    load_tx(8'h3C);
    check("tx_ready after load", 32'(cur_ready()), 32'h0);
    cs_assert();
    exp_q.push_back(8'hA5);
    xfer(8'hA5, 8, mi);
    cs_deassert();
    check("mode0 miso word", 32'(mi), 32'h3C);
    check("mode0 tx_ready after frame", 32'(cur_ready()), 32'h1);

    // Mode 3: preload 0x81, receive 0x7E
    m_sclk = 1'b1;
    sel = 3;
    tick(4);
    load_tx(8'h81);
    cs_assert();
    exp_q.push_back(8'h7E);
    xfer(8'h7E, 8, mi);
    cs_deassert();
    check("mode3 miso word", 32'(mi), 32'h81);

    // Back-to-back under one cs, response 0xF0 loaded during the first word
    m_sclk = 1'b0;
    sel = 0;
    tick(4);
    load_tx(8'h5A);
    cs_assert();
    load_tx(8'hF0);
    check("b2b tx_ready after reload", 32'(cur_ready()), 32'h0);
    exp_q.push_back(8'h11);
    xfer(8'h11, 8, mi);
    check("b2b first miso word", 32'(mi), 32'h5A);
    exp_q.push_back(8'h22);
    xfer(8'h22, 8, mi);
    check("b2b second miso word", 32'(mi), 32'hF0);
    cs_deassert();

    // Abort after 3 sclk cycles
    load_tx(8'hFF);
    cs_assert();
    xfer(8'hFF, 3, mi);
    check("abort partial miso bits", 32'(mi), 32'hE0);
    cs_deassert();
    check("abort miso", 32'(if0.miso), 32'h0);
    check("abort state", 32'(dut0.state), 32'(IDLE));
    cs_assert();
    exp_q.push_back(8'hC3);
    xfer(8'hC3, 8, mi);
    cs_deassert();
    check("after abort miso word", 32'(mi), 32'h00);

    // No preload
    cs_assert();
    exp_q.push_back(8'h55);
    xfer(8'h55, 8, mi);
    check("no preload tx_ready mid", 32'(cur_ready()), 32'h1);
    cs_deassert();
    check("no preload miso word", 32'(mi), 32'h00);
    check("no preload tx_ready", 32'(cur_ready()), 32'h1);

    // Async reset mid-frame
    check("rx_data before reset", 32'(if0.rx_data), 32'h55);
    cs_assert();
    load_tx(8'h99);
    check("tx_ready before reset", 32'(cur_ready()), 32'h0);
    xfer(8'hF0, 2, mi);
    rst = 1'b1;
    #1;
    check("async reset miso", 32'(if0.miso), 32'h0);
    check("async reset rx_data", 32'(if0.rx_data), 32'h0);
    check("async reset rx_valid", 32'(if0.rx_valid), 32'h0);
    check("async reset tx_ready", 32'(if0.tx_ready), 32'h1);
    m_cs = 1'b1;
    m_sclk = 1'b0;
    m_mosi = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(4);
    cs_assert();
    exp_q.push_back(8'h96);
    xfer(8'h96, 8, mi);
    cs_deassert();
    check("post reset miso word", 32'(mi), 32'h00);

`ifdef SPI_SLAVE_OVERRUN_EN
    // Overrun: two words with no response loaded in between
    check("overrun clear before", 32'(if0.rx_overrun), 32'h0);
    cs_assert();
    exp_q.push_back(8'h01);
    xfer(8'h01, 8, mi);
    exp_q.push_back(8'h02);
    xfer(8'h02, 8, mi);
    cs_deassert();
    check("overrun set", 32'(if0.rx_overrun), 32'h1);
    load_tx(8'h00);
    check("overrun cleared by tx_load", 32'(if0.rx_overrun), 32'h0);
`endif

    tick(10);
    check("scoreboard empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
